// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, sensor indices and default sensor addresses
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START_A  = 4'd1,
    START_B  = 4'd2,
    ADDR     = 4'd3,
    ADDR_ACK = 4'd4,
    READ_MSB = 4'd5,
    ACK_MSB  = 4'd6,
    READ_LSB = 4'd7,
    NACK_LSB = 4'd8,
    STOP     = 4'd9,
    DONE     = 4'd10
  } state_t;
  localparam logic [2:0] IDX_SOLAR      = 3'd0;
  localparam logic [2:0] IDX_GREENHOUSE = 3'd1;
  localparam logic [2:0] IDX_AMBIENT    = 3'd2;
  localparam logic [2:0] IDX_GEO        = 3'd3;
  localparam logic [2:0] IDX_N          = 3'd4;
  localparam logic [2:0] IDX_E          = 3'd5;
  localparam logic [2:0] IDX_S          = 3'd6;
  localparam logic [2:0] IDX_W          = 3'd7;
  localparam logic [6:0] DEF_SOLAR_ADDR      = 7'h48;
  localparam logic [6:0] DEF_GREENHOUSE_ADDR = 7'h49;
  localparam logic [6:0] DEF_AMBIENT_ADDR    = 7'h4A;
  localparam logic [6:0] DEF_GEO_ADDR        = 7'h4B;
  localparam logic [6:0] DEF_N_ADDR          = 7'h23;
  localparam logic [6:0] DEF_E_ADDR          = 7'h5C;
  localparam logic [6:0] DEF_S_ADDR          = 7'h29;
  localparam logic [6:0] DEF_W_ADDR          = 7'h39;
endpackage

// File: rtl/i2c_master.sv
// i2c_master: open-drain 2-byte read engine (START, addr+R, MSB, LSB, STOP)
module i2c_master
  import i2c_pkg::*;
#(
  parameter int QTR_CLKS = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  addr,
  output logic        done,
  output logic        ack_ok,
  output logic [15:0] data,
  inout  wire         scl,
  inout  wire         sda
);
  localparam int QW = QTR_CLKS > 1 ? $clog2(QTR_CLKS) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR_CLKS - 1);
  state_t state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0] q;
  logic [2:0] bcnt;
  logic [7:0] addr_byte;
  logic slot_end, sample, last_bit, bit_slot, scl_low, sda_low;
  assign addr_byte = {addr, 1'b1};
  assign slot_end = q == 2'd3 && qcnt == QLAST;
  assign sample = q == 2'd2 && qcnt == '0;
  assign last_bit = slot_end && bcnt == 3'd7;
  assign bit_slot = state inside {ADDR, ADDR_ACK, READ_MSB, ACK_MSB, READ_LSB, NACK_LSB};
  assign scl_low = state == START_B || (bit_slot && (q == 2'd0 || q == 2'd3)) || (state == STOP && q == 2'd0);
  assign sda_low = state inside {START_A, START_B, ACK_MSB} || (state == ADDR && !addr_byte[3'd7 - bcnt]) ||
                   (state == STOP && q != 2'd3);
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? START_A : IDLE;
      START_A:  state_n = slot_end ? START_B : START_A;
      START_B:  state_n = slot_end ? ADDR : START_B;
      ADDR:     state_n = last_bit ? ADDR_ACK : ADDR;
      ADDR_ACK: state_n = slot_end ? (ack_ok ? READ_MSB : STOP) : ADDR_ACK;
      READ_MSB: state_n = last_bit ? ACK_MSB : READ_MSB;
      ACK_MSB:  state_n = slot_end ? READ_LSB : ACK_MSB;
      READ_LSB: state_n = last_bit ? NACK_LSB : READ_LSB;
      NACK_LSB: state_n = slot_end ? STOP : NACK_LSB;
      STOP:     state_n = slot_end ? DONE : STOP;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      qcnt   <= '0;
      q      <= '0;
      bcnt   <= '0;
      ack_ok <= 1'b0;
      data   <= '0;
    end else begin
      state <= state_n;
      qcnt  <= (state_n != state || qcnt == QLAST) ? '0 : qcnt + 1'b1;
      q     <= state_n != state ? 2'd0 : (qcnt == QLAST ? q + 2'd1 : q);
      bcnt  <= state_n != state ? 3'd0 : (slot_end ? bcnt + 3'd1 : bcnt);
      if (state == IDLE && start) ack_ok <= 1'b0;
      if (state == ADDR_ACK && sample) ack_ok <= sda === 1'b0;
      if ((state == READ_MSB || state == READ_LSB) && sample) data <= {data[14:0], sda !== 1'b0};
    end
  end
endmodule

// File: rtl/i2c_control.sv
// i2c_control: round-robin poller of 4 temperature and 4 light sensors over I2C
module i2c_control
  import i2c_pkg::*;
#(
  parameter int         QTR_CLKS        = 125,
  parameter logic [6:0] SOLAR_ADDR      = DEF_SOLAR_ADDR,
  parameter logic [6:0] GREENHOUSE_ADDR = DEF_GREENHOUSE_ADDR,
  parameter logic [6:0] AMBIENT_ADDR    = DEF_AMBIENT_ADDR,
  parameter logic [6:0] GEO_ADDR        = DEF_GEO_ADDR,
  parameter logic [6:0] N_ADDR          = DEF_N_ADDR,
  parameter logic [6:0] E_ADDR          = DEF_E_ADDR,
  parameter logic [6:0] S_ADDR          = DEF_S_ADDR,
  parameter logic [6:0] W_ADDR          = DEF_W_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         scl,
  inout  wire         sda,
  output logic [8:0]  solar_celcius,
  output logic [8:0]  greenhouse_celcius,
  output logic [8:0]  ambient_celcius,
  output logic [8:0]  geothermal_celcius,
  output logic [15:0] n_lux,
  output logic [15:0] e_lux,
  output logic [15:0] s_lux,
  output logic [15:0] w_lux
);
  localparam logic [6:0] ADDR_TAB [8] = '{SOLAR_ADDR, GREENHOUSE_ADDR, AMBIENT_ADDR, GEO_ADDR,
                                          N_ADDR, E_ADDR, S_ADDR, W_ADDR};
  logic [2:0] idx;
  logic done, ack_ok;
  logic [15:0] data;
  logic [8:0] temp;
  assign temp = {data[15:8], data[7]};
  i2c_master #(.QTR_CLKS(QTR_CLKS)) i2c_module (
    .clk(clk), .rst(rst), .start(1'b1), .addr(ADDR_TAB[idx]),
    .done(done), .ack_ok(ack_ok), .data(data), .scl(scl), .sda(sda)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      idx                <= '0;
      solar_celcius      <= '0;
      greenhouse_celcius <= '0;
      ambient_celcius    <= '0;
      geothermal_celcius <= '0;
      n_lux              <= '0;
      e_lux              <= '0;
      s_lux              <= '0;
      w_lux              <= '0;
    end else if (done) begin
      idx <= idx + 3'd1;
      if (ack_ok) begin
        case (idx)
          IDX_SOLAR:      solar_celcius      <= temp;
          IDX_GREENHOUSE: greenhouse_celcius <= temp;
          IDX_AMBIENT:    ambient_celcius    <= temp;
          IDX_GEO:        geothermal_celcius <= temp;
          IDX_N:          n_lux              <= data;
          IDX_E:          e_lux              <= data;
          IDX_S:          s_lux              <= data;
          IDX_W:          w_lux              <= data;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_control.sv
// tb_i2c_control: directed vectors against a bus-level slave model of the sensors
module tb_i2c_control;
  import i2c_pkg::*;
  localparam int QTR = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire scl, sda;
  logic [8:0] solar_celcius, greenhouse_celcius, ambient_celcius, geothermal_celcius;
  logic [15:0] n_lux, e_lux, s_lux, w_lux;
  logic slave_low;
  pullup (scl);
  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;
  i2c_control #(.QTR_CLKS(QTR)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .solar_celcius(solar_celcius), .greenhouse_celcius(greenhouse_celcius),
    .ambient_celcius(ambient_celcius), .geothermal_celcius(geothermal_celcius),
    .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          mode;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    int          ntx;
    int          sel;
    logic [15:0] expv;
    logic [7:0]  exp_addr;
  } vec_t;
  vec_t vecs [12];
  int mode = 0;
  logic [7:0] s_msb = 8'h00;
  logic [7:0] s_lsb = 8'h00;
  int bitpos = 0;
  int cnt6 = 0;
  int cnt8 = 0;
  int viol = 0;
  logic prev_scl = 1'b1;
  logic [7:0] addr_cap = 8'h00;
  state_t st, prev_state;
  logic scl_hi, sda_hi;
  int n_vec = 0;
  int n_cmp = 0;
  int n_fail = 0;
  assign st = dut.i2c_module.state;
  assign scl_hi = scl !== 1'b0;
  assign sda_hi = sda !== 1'b0;
  always_comb
    slave_low = (mode >= 1 && st == ADDR_ACK) ||
                (mode == 2 && bitpos < 8 && ((st == READ_MSB && !s_msb[3'(7 - bitpos)]) ||
                                             (st == READ_LSB && !s_lsb[3'(7 - bitpos)])));
  always @(negedge clk) begin
    prev_scl   <= scl_hi;
    prev_state <= st;
    if (st == START_B) addr_cap <= 8'h00;
    if (st == ADDR && scl_hi && !prev_scl) addr_cap <= {addr_cap[6:0], sda_hi};
    bitpos <= (st != READ_MSB && st != READ_LSB) ? 0 : (prev_scl && !scl_hi ? bitpos + 1 : bitpos);
    if (st != prev_state && st == ACK_MSB) cnt6 <= cnt6 + 1;
    if (st != prev_state && st == NACK_LSB) cnt8 <= cnt8 + 1;
    if ((st == ACK_MSB && sda_hi) || (st == NACK_LSB && !sda_hi)) viol <= viol + 1;
  end
  function automatic logic [15:0] sel_out(int s);
    case (s)
      0: return {7'd0, solar_celcius};
      1: return {7'd0, greenhouse_celcius};
      2: return {7'd0, ambient_celcius};
      3: return {7'd0, geothermal_celcius};
      4: return n_lux;
      5: return e_lux;
      6: return s_lux;
      default: return w_lux;
    endcase
  endfunction
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic check_all_zero(string name);
    check(name, {15'd0, |{solar_celcius, greenhouse_celcius, ambient_celcius, geothermal_celcius,
                          n_lux, e_lux, s_lux, w_lux}}, 16'd0);
  endtask
  task automatic wait_txns(int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (st != DONE && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL txn_timeout: no DONE within %0d clks", t);
        return;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    vecs[0]  = '{0, 8'h00, 8'h00, 1, 0, 16'h0000, 8'h91};
    vecs[1]  = '{0, 8'h00, 8'h00, 7, 7, 16'h0000, 8'h73};
    vecs[2]  = '{1, 8'h00, 8'h00, 1, 0, 16'h01FF, 8'h91};
    vecs[3]  = '{1, 8'h00, 8'h00, 1, 1, 16'h01FF, 8'h93};
    vecs[4]  = '{0, 8'h00, 8'h00, 2, 2, 16'h0000, 8'h97};
    vecs[5]  = '{1, 8'h00, 8'h00, 1, 4, 16'hFFFF, 8'h47};
    vecs[6]  = '{2, 8'h12, 8'h34, 1, 5, 16'h1234, 8'hB9};
    vecs[7]  = '{2, 8'hAB, 8'hCD, 1, 6, 16'hABCD, 8'h53};
    vecs[8]  = '{0, 8'h00, 8'h00, 1, 7, 16'h0000, 8'h73};
    vecs[9]  = '{2, 8'h19, 8'h80, 1, 0, 16'h0033, 8'h91};
    vecs[10] = '{2, 8'hE7, 8'h00, 1, 1, 16'h01CE, 8'h93};
    vecs[11] = '{0, 8'h00, 8'h00, 8, 0, 16'h0033, 8'h93};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    check("reset_scl", {15'd0, scl_hi}, 16'd1);
    check("reset_sda", {15'd0, sda_hi}, 16'd1);
    check("reset_state", {12'd0, st}, 16'd0);
    rst = 1'b0;
    for (int v = 0; v < 12; v++) begin
      n_vec++;
      mode  = vecs[v].mode;
      s_msb = vecs[v].msb;
      s_lsb = vecs[v].lsb;
      wait_txns(vecs[v].ntx);
      check($sformatf("vec%0d_out%0d", v, vecs[v].sel), sel_out(vecs[v].sel), vecs[v].expv);
      check($sformatf("vec%0d_addr", v), {8'd0, addr_cap}, {8'd0, vecs[v].exp_addr});
    end
    check("ack_msb_entries", 16'(cnt6), 16'd7);
    check("nack_lsb_entries", 16'(cnt8), 16'd7);
    check("ack_drive_violations", 16'(viol), 16'd0);
    mode = 1;
    begin
      int t = 0;
      while (st != READ_MSB && t < 2000) begin
        @(negedge clk);
        t++;
      end
      check("reach_read_msb", {12'd0, st}, {12'd0, READ_MSB});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_state", {12'd0, st}, 16'd0);
    check("midreset_scl", {15'd0, scl_hi}, 16'd1);
    check("midreset_sda", {15'd0, sda_hi}, 16'd1);
    check_all_zero("midreset_outputs");
    rst = 1'b0;
    wait_txns(1);
    check("restart_addr", {8'd0, addr_cap}, 16'h0091);
    check("restart_solar", sel_out(0), 16'h01FF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
